// File: rtl/dsp_filt_pkg.sv
// Shared constants and types for the decimating matched filter.
// Holds the symmetric coefficient half-table and the output scaling helper.
package dsp_filt_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int COEF_W    = 18;
  localparam int ACC_W     = 40;
  localparam int PROD_W    = SAMPLE_W + COEF_W;
  localparam int OUT_SHIFT = 17;
  localparam int NUM_COEF  = 11;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  // b[0..10] in 0s18; b[10] is the centre tap, b[k] pairs taps k and 20-k.
  localparam coef_t COEFS [NUM_COEF] = '{
    18'sd4094,   18'sd5900,   18'sd3326,  -18'sd3449,
   -18'sd10679, -18'sd12462, -18'sd4029,   18'sd14915,
    18'sd38991,  18'sd59143,  18'sd66990
  };

  localparam acc_t Y_MAX = 40'sd131071;
  localparam acc_t Y_MIN = -40'sd131072;

  // Floor-scale the accumulator back to 1s17 and clip to the sample range.
  function automatic sample_t scale_sat(input acc_t a);
    acc_t s;
    s = a >>> OUT_SHIFT;
    if (s > Y_MAX)      return sample_t'(Y_MAX);
    else if (s < Y_MIN) return sample_t'(Y_MIN);
    else                return sample_t'(s);
  endfunction

endpackage

// File: rtl/folded_mac.sv
// Folded multiply-accumulate: (x_a + x_b) * coef summed into a 40-bit accumulator.
// One multiplier, shared across all tap pairs by the caller's sequencing.
module folded_mac
  import dsp_filt_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    clr,
  input  sample_t x_a,
  input  sample_t x_b,
  input  coef_t   coef,
  output acc_t    acc
);

  sample_t                    fold;
  logic signed [PROD_W-1:0]   prod;

  // Both operands are halved samples, so the 18-bit pair sum cannot wrap.
  assign fold = x_a + x_b;
  assign prod = PROD_W'(fold) * PROD_W'(coef);

  // NOTE: state updates use <= so every flop samples pre-edge values, avoiding sim/synth races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/decim_matched_filt.sv
// Decimating symmetric FIR: collects DECIM samples, then runs a serial folded MAC
// over the delay line and presents one saturated output sample.
module decim_matched_filt
  import dsp_filt_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int NTAPS = 21
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] x_in,
  input  logic                       x_valid,
  output logic signed [SAMPLE_W-1:0] y,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int HALF  = (NTAPS - 1) / 2;
  localparam int KW    = $clog2(HALF + 1);
  localparam int IDX_W = $clog2(NTAPS);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [KW-1:0]   K_LAST  = KW'(HALF);

  sample_t           dline [NTAPS];
  sample_t           halved;
  logic [PH_W-1:0]   phase;
  state_t            state;
  logic [KW-1:0]     k;
  logic              accept;
  logic              drop;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  sample_t           mac_a;
  sample_t           mac_b;
  logic              mac_en;
  logic              mac_clr;
  acc_t              acc;

  // Arithmetic halve to 2s16 gives the fold adder one bit of headroom.
  assign halved = x_in >>> 1;
  assign accept = x_valid & ~busy;
  assign drop   = x_valid &  busy;

  // NOTE: the delay line is a register bank, not RAM, so it is cleared element by element on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else if (accept) begin
      dline[0] <= halved;
      for (int i = 1; i < NTAPS; i++) dline[i] <= dline[i-1];
    end
  end

  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    idx_a = IDX_W'(k);
    idx_b = IDX_W'(NTAPS - 1) - IDX_W'(k);
    mac_a = dline[idx_a];
    mac_b = (k == K_LAST) ? '0 : dline[idx_b];
  end

  assign mac_en  = (state == ST_MAC);
  assign mac_clr = (k == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      k       <= '0;
      phase   <= '0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (accept) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept && phase == PH_LAST) begin
            state <= ST_MAC;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        ST_MAC: begin
          if (k == K_LAST) state <= ST_OUT;
          else             k     <= k + 1'b1;
        end
        ST_OUT: begin
          y       <= scale_sat(acc);
          y_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  folded_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .clr   (mac_clr),
    .x_a   (mac_a),
    .x_b   (mac_b),
    .coef  (COEFS[k]),
    .acc   (acc)
  );

endmodule

// File: tb/tb_decim_matched_filt.sv
// Scoreboard bench for decim_matched_filt: a direct-form convolution model predicts
// each output and its arrival edge; a negedge monitor compares whatever the DUT emits.
module tb_decim_matched_filt;

  localparam int DECIM = 4;
  localparam int NTAPS = 21;
  localparam int LAT   = 12;
  localparam int NEVER = 1 << 30;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] x_in;
  logic               x_valid;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  decim_matched_filt #(.DECIM(DECIM), .NTAPS(NTAPS)) dut (
    .clk     (clk),
    .reset   (reset),
    .x_in    (x_in),
    .x_valid (x_valid),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int yv;
  } exp_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   coef [11] = '{4094, 5900, 3326, -3449, -10679, -12462, -4029, 14915, 38991, 59143, 66990};
  int   hist [$];
  exp_t expq [$];
  int   ylog [$];
  int   acc_cnt;
  int   t0;
  int   first_drop;
  int   held_y;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int model_y();
    longint s = 0;
    longint q;
    for (int n = 0; n < NTAPS; n++) begin
      int xn  = (n < hist.size()) ? hist[n] : 0;
      int tap = (n <= NTAPS - 1 - n) ? n : NTAPS - 1 - n;
      s += longint'(xn) * longint'(coef[tap]);
    end
    q = s >>> 17;
    if (q > 131071)  q = 131071;
    if (q < -131072) q = -131072;
    return int'(q);
  endfunction

  function automatic void model_reset();
    hist.delete();
    expq.delete();
    acc_cnt    = 0;
    t0         = -100;
    first_drop = NEVER;
    held_y     = 0;
  endfunction

  // A sample on edge e is lost if a computation started within the previous LAT edges.
  function automatic void present(input logic signed [17:0] v, input int e);
    if (e >= t0 + 1 && e <= t0 + LAT) begin
      if (e < first_drop) first_drop = e;
    end else begin
      hist.push_front(int'(v) >>> 1);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      if (acc_cnt % DECIM == DECIM - 1) begin
        t0 = e;
        expq.push_back('{due: e + LAT, yv: model_y()});
      end
      acc_cnt++;
    end
  endfunction

  // Called #1 after an edge; the sample lands on the next edge, then gap edges elapse.
  task automatic send(input logic signed [17:0] v, input int gap);
    x_in    = v;
    x_valid = 1'b1;
    present(v, cyc + 1);
    repeat (gap) begin
      @(posedge clk);
      #1;
      x_valid = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (24) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t ent;
    if (mon_en) begin
      if (y_valid) begin
        ylog.push_back(int'(y));
        if (expq.size() == 0) begin
          check("unexpected_y_valid", 1, 0);
        end else begin
          ent = expq.pop_front();
          check("y_latency", cyc, ent.due);
          check("y_value", y, ent.yv);
          held_y = ent.yv;
        end
      end else begin
        check("y_hold", y, held_y);
        if (expq.size() != 0 && expq[0].due < cyc) begin
          check("y_valid_missing", 0, 1);
          void'(expq.pop_front());
        end
      end
      check("busy", busy, (cyc >= t0 && cyc <= t0 + LAT - 1));
      check("overrun", overrun, (cyc >= first_drop));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int imp_exp [6] = '{-863, 3728, 14785, -3116, 1475, 0};
    logic signed [17:0] v;

    reset   = 1'b1;
    x_valid = 1'b0;
    x_in    = '0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("reset_y", y, 0);
    check("reset_y_valid", y_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Impulse: half-scale sample picks out b[k]/4 at the decimated taps.
    ylog.delete();
    send(18'sd65536, 16);
    for (int i = 0; i < 23; i++) send(18'sd0, 16);
    drain();
    check("impulse_count", ylog.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("impulse_y%0d", i), (i < ylog.size()) ? ylog[i] : 999999, imp_exp[i]);

    // DC at both full-scale extremes.
    ylog.delete();
    for (int i = 0; i < 24; i++) send(18'sd131071, 16);
    drain();
    check("dc_pos", (ylog.size() > 0) ? ylog[$] : 999999, 129243);
    ylog.delete();
    for (int i = 0; i < 24; i++) send(-18'sd131072, 16);
    drain();
    check("dc_neg", (ylog.size() > 0) ? ylog[$] : 999999, -129245);

    // Random data, spacing never short enough to drop.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0:       v = 18'sh1FFFF;
        1:       v = 18'sh20000;
        default: v = 18'($urandom());
      endcase
      send(v, $urandom_range(13, 24));
    end
    drain();

    // Reset five edges into a computation.
    while (acc_cnt % DECIM != DECIM - 1) send(18'($urandom()), 16);
    x_in    = 18'($urandom());
    x_valid = 1'b1;
    present(x_in, cyc + 1);
    @(posedge clk);
    #1 x_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("midmac_y", y, 0);
    check("midmac_y_valid", y_valid, 0);
    check("midmac_busy", busy, 0);
    check("midmac_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    ylog.delete();
    for (int i = 0; i < 4; i++) send(18'($urandom()), 16);
    drain();
    check("post_reset_outputs", ylog.size(), 1);

    // Tight spacing: samples landing inside a computation are dropped.
    for (int i = 0; i < 48; i++) send(18'($urandom()), 4);
    drain();
    check("overrun_sticky", overrun, 1);
    check("scoreboard_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decim_matched_filt.md
DECIM_MATCHED_FILT -- requirements
Module: decim_matched_filt

Interface
REQ-001 SHALL have parameters: DECIM, default 4, output decimation ratio; NTAPS, default 21, symmetric tap count (odd).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- x_in  input  18  signed 1s17 sample, receive side.
- x_valid  input  1  sample strobe; x_in is accepted on any clk edge where this is high and busy is low.
- y  output  18  signed 1s17 filtered, decimated output.
- y_valid  output  1  one-cycle pulse marking a new y.
- busy  output  1  high while a MAC computation is in progress.
- overrun  output  1  sticky flag: a sample was dropped.

Function
REQ-003 SHALL sign-extend and arithmetic-halve each accepted sample to 2s16, as {x_in[17], x_in[17:1]}, before it enters the delay line.
REQ-004 SHALL hold an NTAPS-deep sample delay line (x[0] newest) that shifts only on accepted samples.
REQ-005 SHALL keep a phase counter 0..DECIM-1 that increments on each accepted sample and wraps to 0.
REQ-006 SHALL start a computation on the edge that accepts a sample while the counter equals DECIM-1 (edge T0).
REQ-007 SHALL implement FSM states IDLE -> MAC -> OUT -> IDLE:
- IDLE -> MAC at T0.
- MAC on edges T1..T11, tap index k = 0..10.
- OUT at T12: y is updated and y_valid is high for exactly one cycle.
- Then back to IDLE.
REQ-008 SHALL use one 18x18 signed multiplier, time-shared. Per k<10: product = (x[k] + x[20-k]) * b[k]. For k=10: product = x[10] * b[10].
REQ-009 SHALL compute the folded sum at 18 bits (2s16; cannot overflow) and the product at 36 bits (2s34).
REQ-010 SHALL accumulate products at full precision in a 40-bit signed accumulator that is cleared at T1.
REQ-011 SHALL form y as accumulator arithmetic-shifted right 17 (floor, no rounding), saturated to [-131072, 131071].
REQ-012 SHALL use coefficients b[0..10] (0s18) = 4094, 5900, 3326, -3449, -10679, -12462, -4029, 14915, 38991, 59143, 66990.
REQ-013 SHALL assert busy from the cycle after T0 through the OUT cycle inclusive.
REQ-014 SHALL drop any sample presented with x_valid high while busy is high: no shift, no counter change. It SHALL set overrun to 1 on the following edge.
REQ-015 SHALL hold y between y_valid pulses. Latency is 12 clk edges from the accepting edge T0 to y_valid.
REQ-016 SHALL sustain full throughput when x_valid spacing is at least 16 cycles; no overrun occurs under that condition.

Reset
REQ-017 SHALL, while reset is low, asynchronously clear:
- the delay line, phase counter, accumulator and y to 0;
- the FSM to IDLE;
- y_valid, busy and overrun to 0.
REQ-018 SHALL abandon an in-flight computation on reset mid-MAC: no y_valid afterwards, and the first output after release follows the DECIM-th accepted sample.
REQ-019 SHALL clear overrun only by reset.

Structure
REQ-020 SHALL place in the shared package dsp_filt_pkg:
- the coefficient table;
- the sample/coefficient/accumulator widths (18/18/40);
- the shift constant 17.
REQ-021 SHALL isolate the fold/multiply/accumulate datapath in one sub-module, folded_mac. The FSM, counter, delay line and flags stay in the top module.

Verification (samples spaced 16 cycles unless stated)
REQ-022 Impulse response: x_in=65536 on the first sample, then zeros -> y sequence -863, 3728, 14785, -3116, 1475, then 0 thereafter.
REQ-023 DC: x_in=131071 continuously -> y settles to 129243. With x_in=-131072 continuously -> y settles to -129245.
REQ-024 Latency: any starting sample -> y_valid is high exactly 12 edges after the accepting edge, for one cycle; busy is high for 12 cycles.
REQ-025 Overrun: samples spaced 4 cycles -> exactly the samples arriving while busy are dropped and overrun rises after the first drop; the output matches a model that omits the dropped samples.
REQ-026 Reset mid-MAC: reset asserted at T5 for 3 cycles -> all outputs are 0 immediately; no y_valid; the next y_valid follows 4 accepted samples after release.
